// File: rtl/mips32_prog_loader.sv
// rtl/mips32_prog_loader.sv - byte-stream program loader writing 32-bit words into processor memory
module mips32_prog_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              proc_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_written
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, FIN} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         csum;
    logic [23:0]        word_buf;
    logic [1:0]         byte_idx;
    logic [CNT_W-1:0]   ww_next;
    logic               accept;

    assign ww_next = words_written + CNT_W'(1);
    assign accept  = in_valid && in_ready;

    always_ff @(posedge clk1) begin
        if (rst) begin
            state         <= IDLE;
            base_q        <= '0;
            cnt_q         <= '0;
            csum          <= '0;
            word_buf      <= '0;
            byte_idx      <= '0;
            in_ready      <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            proc_hold     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        base_q        <= base_addr;
                        cnt_q         <= word_count;
                        words_written <= '0;
                        csum          <= '0;
                        byte_idx      <= '0;
                        done          <= 1'b0;
                        err           <= 1'b0;
                        busy          <= 1'b1;
                        proc_hold     <= 1'b1;
                        in_ready      <= 1'b1;
                        state         <= (word_count == '0) ? CHECK : LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        word_buf <= {word_buf[15:0], in_data};
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        // Fourth byte: launch the write with the full word already registered
                        if (byte_idx == 2'd3) begin
                            state     <= WRITE;
                            in_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= base_q + ADDR_W'(words_written);
                            mem_wdata <= {word_buf, in_data};
                        end
                    end
                end
                WRITE: begin
                    mem_we        <= 1'b0;
                    words_written <= ww_next;
                    in_ready      <= 1'b1;
                    state         <= (ww_next == cnt_q) ? CHECK : LOAD;
                end
                CHECK: begin
                    if (accept) begin
                        state     <= FIN;
                        in_ready  <= 1'b0;
                        done      <= 1'b1;
                        err       <= (in_data != csum);
                        busy      <= 1'b0;
                        proc_hold <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb/tb_mips32_prog_loader.sv - directed scoreboard bench for mips32_prog_loader
module tb_mips32_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        proc_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  words_written;

    int passed = 0;
    int total  = 0;
    int writes_seen = 0;
    logic [41:0] exp_q[$];
    logic [7:0]  stream[12] = '{8'h28, 8'h01, 8'h00, 8'h64, 8'h0C, 8'hE7,
                                8'h78, 8'h00, 8'hFC, 8'h00, 8'h00, 8'h00};

    always #5 clk1 = ~clk1;

    mips32_prog_loader #(.ADDR_W(10), .CNT_W(10)) dut (
        .clk1(clk1), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .proc_hold(proc_hold), .busy(busy),
        .done(done), .err(err), .words_written(words_written)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk1) begin
        if (!rst && mem_we) begin
            logic [41:0] e;
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("mem_addr", {22'd0, mem_addr}, {22'd0, e[41:32]});
                check("mem_wdata", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bubbles);
        bit ok;
        ok = 1'b0;
        if (bubbles) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk1); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk1);
            if (in_ready) begin
                @(posedge clk1); #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_proc_hold"}, {31'd0, proc_hold}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_words_written"}, {22'd0, words_written}, 32'd0);
    endtask

    task automatic run_load(input logic [9:0] base, input int n, input bit bad,
                            input bit bubbles, input bit poke);
        logic [7:0]  cs;
        logic [9:0]  a;
        logic [31:0] w;
        cs = 8'h00;
        in_valid   = 1'b0;
        base_addr  = base;
        word_count = 10'(n);
        start      = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("hold_after_start", {31'd0, proc_hold}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
        for (int i = 0; i < n; i++) begin
            a = base + 10'(i);
            w = {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
            exp_q.push_back({a, w});
            for (int j = 0; j < 4; j++) begin
                cs = cs ^ stream[4*i+j];
                send_byte(stream[4*i+j], bubbles);
                if (poke && i == 1 && j == 1) begin
                    start      = 1'b1;
                    base_addr  = 10'd7;
                    word_count = 10'd1;
                    @(posedge clk1); #1;
                    start = 1'b0;
                    check("start_ignored_busy", {31'd0, busy}, 32'd1);
                    check("start_ignored_ww", {22'd0, words_written}, 32'd1);
                end
            end
            @(negedge clk1);
            check("we_after_4th", {31'd0, mem_we}, 32'd1);
        end
        send_byte(bad ? (cs ^ 8'h01) : cs, bubbles);
        check("done", {31'd0, done}, 32'd1);
        check("err", {31'd0, err}, {31'd0, bad});
        check("words_written", {22'd0, words_written}, 32'(n));
        check("busy_at_fin", {31'd0, busy}, 32'd0);
        check("hold_at_fin", {31'd0, proc_hold}, 32'd0);
        check("ready_at_fin", {31'd0, in_ready}, 32'd0);
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
        @(posedge clk1); #1;
        check("done_held", {31'd0, done}, 32'd1);
        check("err_held", {31'd0, err}, {31'd0, bad});
    endtask

    initial begin
        int w_before;
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk1);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk1); #1;

        run_load(10'd0, 3, 1'b0, 1'b0, 1'b0);
        run_load(10'd0, 3, 1'b1, 1'b0, 1'b0);
        run_load(10'd1023, 2, 1'b0, 1'b0, 1'b0);

        w_before   = writes_seen;
        base_addr  = 10'd5;
        word_count = 10'd0;
        start      = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h00;
        @(posedge clk1); #1;
        start = 1'b0;
        check("cnt0_busy", {31'd0, busy}, 32'd1);
        check("cnt0_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk1); #1;
        in_valid = 1'b0;
        check("cnt0_done", {31'd0, done}, 32'd1);
        check("cnt0_err", {31'd0, err}, 32'd0);
        check("cnt0_ww", {22'd0, words_written}, 32'd0);
        check("cnt0_no_write", 32'(writes_seen - w_before), 32'd0);

        w_before   = writes_seen;
        base_addr  = 10'd0;
        word_count = 10'd3;
        start      = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        exp_q.push_back({10'd0, 32'h28010064});
        for (int j = 0; j < 6; j++) send_byte(stream[j], 1'b0);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk1); #1;
        rst   = 1'b0;
        start = 1'b0;
        check_all_zero("midrst");
        check("midrst_one_write", 32'(writes_seen - w_before), 32'd1);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk1); #1;
        check("midrst_idle", {31'd0, busy}, 32'd0);
        run_load(10'd0, 3, 1'b0, 1'b0, 1'b0);

        run_load(10'd0, 3, 1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips32_prog_loader.md
MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the width of the memory word address.
REQ-002 SHALL have parameter CNT_W, default 10, giving the width of the word-count field.
REQ-003 SHALL have port clk1, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a load.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: first memory word address, sampled at start.
REQ-007 SHALL have port word_count, input, CNT_W bits: number of 32-bit words to load, sampled at start.
REQ-008 SHALL have port in_valid, input, 1 bit: byte-stream data valid.
REQ-009 SHALL have port in_data, input, 8 bits: byte-stream data.
REQ-010 SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-011 SHALL have port mem_we, output, 1 bit: memory write strobe.
REQ-012 SHALL have port mem_addr, output, ADDR_W bits: memory write address.
REQ-013 SHALL have port mem_wdata, output, 32 bits: memory write data.
REQ-014 SHALL have port proc_hold, output, 1 bit: keeps the processor halted while loading.
REQ-015 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-016 SHALL have port done, output, 1 bit: load finished, held until the next start or rst.
REQ-017 SHALL have port err, output, 1 bit: checksum mismatch, valid while done=1.
REQ-018 SHALL have port words_written, output, CNT_W bits: count of words written in the current or last load.

Function
REQ-019 SHALL implement the states IDLE, LOAD, WRITE, CHECK and FIN.
REQ-020 SHALL accept start only in IDLE or FIN: latch base_addr and word_count, clear words_written, checksum, done and err; go to LOAD, or to CHECK if word_count=0.
REQ-021 SHALL ignore start while in LOAD, WRITE or CHECK.
REQ-022 SHALL transfer a byte only when in_valid=1 and in_ready=1 in the same cycle.
REQ-023 SHALL drive in_ready=1 only in LOAD and CHECK.
REQ-024 SHALL assemble bytes MSB first in LOAD: the word equals {b0,b1,b2,b3}.
REQ-025 SHALL XOR every data byte accepted in LOAD into an 8-bit running checksum.
REQ-026 SHALL enter WRITE in the cycle after the 4th byte of a word is accepted.
REQ-027 SHALL, in WRITE, hold mem_we=1 for exactly one cycle with mem_addr=(base_addr+words_written) mod 2^ADDR_W and mem_wdata equal to the assembled word.
REQ-028 SHALL, in WRITE, increment words_written, then go to CHECK if the new value equals word_count, otherwise to LOAD.
REQ-029 SHALL drive mem_we=0 in every state other than WRITE.
REQ-030 SHALL, in CHECK, compare one accepted byte with the running checksum, then go to FIN with done=1 and err=(mismatch) in the following cycle.
REQ-031 SHALL hold done, err and words_written in FIN until a new start is accepted or rst is asserted.
REQ-032 SHALL keep proc_hold=1 and busy=1 from the cycle after start acceptance until the cycle FIN is entered, and 0 otherwise.
REQ-033 SHALL allow in_valid gaps (bubbles) at any point without losing state.

Reset
REQ-034 SHALL, while rst=1, force IDLE with in_ready, mem_we, proc_hold, busy, done and err at 0, and mem_addr, mem_wdata, words_written and the checksum at 0.
REQ-035 SHALL, when rst is asserted mid-load, abandon the load; words already written to memory are not undone.
REQ-036 SHALL give rst priority over start when both are high in the same cycle.

Verification
REQ-037 SHALL pass this scenario: base=0, count=3, bytes 28 01 00 64 0C E7 78 00 FC 00 00 00, then 22 -> writes mem[0]=28010064, mem[1]=0CE77800, mem[2]=FC000000; done=1, err=0, words_written=3.
REQ-038 SHALL pass this scenario: same stream with checksum byte 23 -> all three writes occur; done=1, err=1.
REQ-039 SHALL pass this scenario: base=1023, count=2 -> writes to addresses 1023, then 0 (wrap-around).
REQ-040 SHALL pass this scenario: count=0, checksum byte 00 -> no mem_we; done=1, err=0 two cycles after start.
REQ-041 SHALL pass this scenario: rst pulse after 6 bytes of a 3-word load -> exactly 1 write seen; all outputs 0 after the pulse; a new load then completes normally.
REQ-042 SHALL pass this scenario: random in_valid bubbles and a start pulse mid-load -> start ignored; written data identical to the no-bubble run; mem_we asserted 1 cycle after each 4th byte.
